// File: rtl/vgaconsole_term.sv
// Byte-stream terminal front-end for the VGA console text buffer: cursor tracking, control codes, clear and scroll.
// Optional build macro VGACONSOLE_TERM_AUTOWRAP_EN: a printable in the last column wraps, and scrolls if on the last row.
module vgaconsole_term #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [6:0] wr_data,
  output logic [5:0] rd_addr,
  input  logic [6:0] rd_data,
  output logic [1:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy
);

  localparam logic [5:0] COLS6     = 6'(NUM_COLS);
  localparam logic [5:0] LAST_CELL = 6'(NUM_ROWS * NUM_COLS - 1);
  localparam logic [5:0] COPY_LAST = 6'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [1:0] LAST_ROW  = 2'(NUM_ROWS - 1);
  localparam logic [3:0] LAST_COL  = 4'(NUM_COLS - 1);
  localparam logic [6:0] SPACE     = 7'h20;

  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL_COPY, SCROLL_FILL} state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic       wr_en_q, wr_en_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic [6:0] wr_data_q, wr_data_d;
  logic [5:0] cur_addr;

  assign cur_addr = 6'(row_q) * COLS6 + 6'(col_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = in_data[6:0];
            if (col_q < LAST_COL) begin
              col_d = col_q + 4'd1;
            end else begin
`ifdef VGACONSOLE_TERM_AUTOWRAP_EN
              col_d = 4'd0;
              if (row_q < LAST_ROW) begin
                row_d = row_q + 2'd1;
              end else begin
                state_d = SCROLL_COPY;
                cnt_d   = 6'd0;
              end
`else
              col_d = col_q;
`endif
            end
          end else if (in_data == 8'h0A) begin
            col_d = 4'd0;
            if (row_q < LAST_ROW) begin
              row_d = row_q + 2'd1;
            end else begin
              state_d = SCROLL_COPY;
              cnt_d   = 6'd0;
            end
          end else if (in_data == 8'h0D) begin
            col_d = 4'd0;
          end else if (in_data == 8'h08) begin
            if (col_q != 4'd0) col_d = col_q - 4'd1;
          end else if (in_data == 8'h0C) begin
            state_d = CLEAR;
            cnt_d   = 6'd0;
          end
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = SPACE;
        if (cnt_q == LAST_CELL) begin
          state_d = IDLE;
          row_d   = 2'd0;
          col_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      SCROLL_COPY: begin
        // rd_data belongs to the row below; it lands one row up next cycle
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = rd_data;
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == COPY_LAST) state_d = SCROLL_FILL;
      end
      SCROLL_FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = SPACE;
        if (cnt_q == LAST_CELL) state_d = IDLE;
        else cnt_d = cnt_q + 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      row_q     <= 2'd0;
      col_q     <= 4'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 6'd0;
      wr_data_q <= 7'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = !in_ready;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_addr    = (state_q == SCROLL_COPY) ? cnt_q + COLS6 : 6'd0;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule
